div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div_pkg.sv | 8 +
 rtl/div.sv | 130 +++++++++++++
 tb/tb_div.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared processor definitions for the multiply/divide units.
// Operation encoding for the op input: unsigned or signed two's complement.
package div_pkg;

    localparam logic OP_DIVU = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/div.sv
// Iterative restoring divider: one quotient bit per cycle, then sign fix-up.
// Latency: done pulses WIDTH+1 cycles after start is accepted, independent of operands.
// Backpressure: busy holds off new work; start while busy is ignored.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             sign_a;
    logic             sign_b;

    logic             sa_in;
    logic             sb_in;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes; -(2^(WIDTH-1)) maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        sa_in    = (op == OP_DIV) & opA[WIDTH-1];
        sb_in    = (op == OP_DIV) & opB[WIDTH-1];
        a_mag_in = sa_in ? -opA : opA;
        b_mag_in = sb_in ? -opB : opB;
    end

    // One restoring step on a WIDTH+1-bit partial remainder.
    always_comb begin
        rem_sh  = {rem, quo[WIDTH-1]};
        ge      = rem_sh >= {1'b0, b_mag};
        rem_nxt = ge ? WIDTH'(rem_sh - {1'b0, b_mag}) : rem_sh[WIDTH-1:0];
    end

    always_comb begin
        q_fix = (sign_a ^ sign_b) ? -quo : quo;
        r_fix = sign_a ? -rem : rem;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            a_raw  <= '0;
            b_mag  <= '0;
            quo    <= '0;
            rem    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_raw  <= opA;
                        quo    <= a_mag_in;
                        b_mag  <= b_mag_in;
                        rem    <= '0;
                        cnt    <= '0;
                        sign_a <= sa_in;
                        sign_b <= sb_in;
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    // Divide by zero bypasses sign correction: all-ones quotient, raw dividend as remainder.
                    if (b_mag == '0) begin
                        lo <= '1;
                        hi <= a_raw;
                    end else begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for div at WIDTH=32: results, latency, busy, ignored start, reset abort.
module tb_div;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        op;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    div #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .opA   (opA),
        .opB   (opB),
        .op    (op),
        .start (start),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Caller sits 1ns after a rising edge; the next edge accepts the start.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic o, input logic [31:0] elo, input logic [31:0] ehi);
        int cyc;
        int bcnt;
        opA   = a;
        opB   = b;
        op    = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        opA   = 32'hDEAD_BEEF;
        opB   = 32'h0BAD_F00D;
        cyc   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) bcnt++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd33);
        check({tag, " busy cycles"}, 32'(bcnt), 32'd33);
        check({tag, " lo"}, lo, elo);
        check({tag, " hi"}, hi, ehi);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int dones;

        reset = 1'b1;
        opA   = '0;
        opB   = '0;
        op    = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset hi", hi, 32'd0);
        reset = 1'b0;

        // First start accepted in the first cycle out of reset.
        run_div("divu 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        idle_cycle();
        run_div("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        idle_cycle();
        run_div("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
        idle_cycle();
        run_div("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        idle_cycle();
        run_div("divu max/16", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF);
        idle_cycle();
        run_div("divu big/max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
        idle_cycle();
        run_div("div -100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE);
        idle_cycle();
        run_div("divu x/0", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
        idle_cycle();
        run_div("div x/0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);

        // Back-to-back: second start issued in the done cycle.
        run_div("b2b second", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0);

        repeat (5) idle_cycle();
        check("hold done", {31'b0, done}, 32'd0);
        check("hold lo", lo, 32'd100);
        check("hold hi", hi, 32'd0);

        // Start while busy is ignored; operand changes mid-run have no effect.
        opA   = 32'd100;
        opB   = 32'd7;
        op    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        repeat (4) begin
            idle_cycle();
            cyc++;
        end
        opA   = 32'd50;
        opB   = 32'd5;
        start = 1'b1;
        idle_cycle();
        cyc++;
        start = 1'b0;
        opA   = 32'd1234;
        while (!done && cyc < 100) begin
            idle_cycle();
            cyc++;
        end
        check("ignore latency", 32'(cyc), 32'd33);
        check("ignore lo", lo, 32'd14);
        check("ignore hi", hi, 32'd2);
        dones = 0;
        repeat (40) begin
            idle_cycle();
            if (done) dones++;
        end
        check("ignore extra done", 32'(dones), 32'd0);

        // Reset in the middle of a divide aborts it.
        opA   = 32'd1000;
        opB   = 32'd3;
        op    = 1'b0;
        start = 1'b1;
        idle_cycle();
        start = 1'b0;
        repeat (10) idle_cycle();
        reset = 1'b1;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort hi", hi, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            idle_cycle();
            if (done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        run_div("divu 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
